// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - FSM states, position codes and counter widths for the servo PWM decoder
package servo_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      HIGH      = 2'd2,
      LOW       = 2'd3
   } servo_state_t;

   localparam logic [1:0] POS_1MS   = 2'd0;
   localparam logic [1:0] POS_1P5MS = 2'd1;
   localparam logic [1:0] POS_2MS   = 2'd2;

   localparam int POS_T1 = 9;
   localparam int POS_T2 = 14;

   localparam int HI_W  = 8;
   localparam int PER_W = 9;

   function automatic logic [1:0] pos_of(input logic [HI_W-1:0] w);
      if (w <= HI_W'(POS_T1))
         return POS_1MS;
      else if (w <= HI_W'(POS_T2))
         return POS_1P5MS;
      else
         return POS_2MS;
   endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// rtl/servo_tick_gen.sv - measurement tick prescaler with synchronous restart
module servo_tick_gen #(
   parameter int PRESCALE = 5000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_cnt;

   // The tick is not masked by i_clr so a tick landing on a restart edge still counts.
   assign o_tick = (r_cnt == LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr || o_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo pulse width/period decoder with loss-of-signal detection
// Optional GLITCH_FILTER_EN: 4-sample level filter after the synchronizer.
module servo_pwm_decoder
   import servo_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 10_000,
   parameter int MIN_HIGH   = 5,
   parameter int MAX_HIGH   = 25,
   parameter int LOST_TICKS = 250
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_pwm_in,
   input  logic              i_pol,
   output logic [HI_W-1:0]   o_width,
   output logic [PER_W-1:0]  o_period,
   output logic [1:0]        o_position,
   output logic              o_width_valid,
   output logic              o_pulse_err,
   output logic              o_signal_lost
);

   logic               r_sync1, r_sync2;
   logic               w_clean, w_line, r_line_q, w_rise, w_fall;
   logic               w_tick;
   servo_state_t       r_state, w_state_nxt;
   logic [HI_W-1:0]    r_hi_cnt, w_hi_inc;
   logic [PER_W-1:0]   r_per_cnt, w_per_inc;
   logic               w_lost, w_legal;
   logic               w_clr_cnt, w_latch_per, w_eval;
   logic [HI_W-1:0]    r_width;
   logic [PER_W-1:0]   r_period;
   logic [1:0]         r_position;
   logic               r_width_valid, r_pulse_err, r_signal_lost;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_pwm_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef GLITCH_FILTER_EN
   logic       r_flt;
   logic [1:0] r_flt_cnt;

   // Level follows the synchronized pin only after four consecutive differing samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flt     <= 1'b0;
         r_flt_cnt <= 2'd0;
      end else if (r_sync2 == r_flt) begin
         r_flt_cnt <= 2'd0;
      end else if (r_flt_cnt == 2'd3) begin
         r_flt     <= r_sync2;
         r_flt_cnt <= 2'd0;
      end else begin
         r_flt_cnt <= r_flt_cnt + 2'd1;
      end
   end

   assign w_clean = r_flt;
`else
   assign w_clean = r_sync2;
`endif

   assign w_line = w_clean ~^ i_pol;
   assign w_rise = w_line & ~r_line_q;
   assign w_fall = ~w_line & r_line_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_line_q <= 1'b0;
      else
         r_line_q <= w_line;
   end

   servo_tick_gen #(
      .PRESCALE (CLK_HZ / TICK_HZ)
   ) u_tick_gen (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_rise),
      .o_tick  (w_tick)
   );

   assign w_hi_inc  = (w_tick && (r_hi_cnt != '1))  ? r_hi_cnt + HI_W'(1)   : r_hi_cnt;
   assign w_per_inc = (w_tick && (r_per_cnt != '1)) ? r_per_cnt + PER_W'(1) : r_per_cnt;
   assign w_lost    = (w_per_inc == PER_W'(LOST_TICKS)) && (r_per_cnt != PER_W'(LOST_TICKS));
   assign w_legal   = (w_hi_inc >= HI_W'(MIN_HIGH)) && (w_hi_inc <= HI_W'(MAX_HIGH));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr_cnt   = 1'b0;
      w_latch_per = 1'b0;
      w_eval      = 1'b0;
      if (w_lost) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:      if (!w_line) w_state_nxt = WAIT_RISE;
            WAIT_RISE: if (w_rise) begin
               w_clr_cnt   = 1'b1;
               w_state_nxt = HIGH;
            end
            HIGH:      if (w_fall) begin
               w_eval      = 1'b1;
               w_state_nxt = LOW;
            end
            LOW:       if (w_rise) begin
               w_clr_cnt   = 1'b1;
               w_latch_per = 1'b1;
               w_state_nxt = HIGH;
            end
            default:   w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hi_cnt      <= '0;
         r_per_cnt     <= '0;
         r_width       <= '0;
         r_period      <= '0;
         r_position    <= POS_1MS;
         r_width_valid <= 1'b0;
         r_pulse_err   <= 1'b0;
         r_signal_lost <= 1'b1;
      end else begin
         r_width_valid <= w_eval && w_legal;
         r_pulse_err   <= w_eval && !w_legal;
         if (w_clr_cnt)
            r_hi_cnt <= '0;
         else if (r_state == HIGH)
            r_hi_cnt <= w_hi_inc;
         r_per_cnt <= w_clr_cnt ? '0 : w_per_inc;
         if (w_latch_per)
            r_period <= w_per_inc;
         if (w_eval && w_legal) begin
            r_width    <= w_hi_inc;
            r_position <= pos_of(w_hi_inc);
         end
         if (w_lost)
            r_signal_lost <= 1'b1;
         else if (w_eval && w_legal)
            r_signal_lost <= 1'b0;
      end
   end

   assign o_width       = r_width;
   assign o_period      = r_period;
   assign o_position    = r_position;
   assign o_width_valid = r_width_valid;
   assign o_pulse_err   = r_pulse_err;
   assign o_signal_lost = r_signal_lost;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - scoreboard bench for servo_pwm_decoder
`timescale 1ns/1ps
module tb_servo_pwm_decoder;
   import servo_pkg::*;

   localparam int CLK_HZ  = 100_000;
   localparam int TICK_HZ = 10_000;
   localparam int P       = CLK_HZ / TICK_HZ;
   localparam int FRAME   = 200 * P;
`ifdef GLITCH_FILTER_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       pwm_in = 1'b0;
   logic       pol    = 1'b1;
   logic [7:0] o_width;
   logic [8:0] o_period;
   logic [1:0] o_position;
   logic       o_width_valid, o_pulse_err, o_signal_lost;

   typedef struct packed {
      logic       is_err;
      logic [7:0] width;
      logic [1:0] pos;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   servo_pwm_decoder #(
      .CLK_HZ     (CLK_HZ),
      .TICK_HZ    (TICK_HZ),
      .MIN_HIGH   (5),
      .MAX_HIGH   (25),
      .LOST_TICKS (250)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_pwm_in      (pwm_in),
      .i_pol         (pol),
      .o_width       (o_width),
      .o_period      (o_period),
      .o_position    (o_position),
      .o_width_valid (o_width_valid),
      .o_pulse_err   (o_pulse_err),
      .o_signal_lost (o_signal_lost)
   );

   always @(negedge clk) begin
      if (rst_n && (o_width_valid || o_pulse_err)) begin
         checks++;
         if (o_width_valid && o_pulse_err) begin
            failures++;
            $display("FAIL strobe_exclusive: valid=1 err=1, required only one");
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: valid=%0b err=%0b width=%0d, required none",
                     o_width_valid, o_pulse_err, o_width);
         end else begin
            mon_e = exp_q.pop_front();
            if (o_pulse_err !== mon_e.is_err) begin
               failures++;
               $display("FAIL strobe_kind: err=%0b, required err=%0b", o_pulse_err, mon_e.is_err);
            end else if (!mon_e.is_err) begin
               checks++;
               if (o_width !== mon_e.width || o_position !== mon_e.pos) begin
                  failures++;
                  $display("FAIL width_pos: width=%0d pos=%0d, required width=%0d pos=%0d",
                           o_width, o_position, mon_e.width, mon_e.pos);
               end
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_line(input logic lvl);
      pwm_in = pol ? lvl : ~lvl;
   endtask

   task automatic frame(input int hi, input int total);
      set_line(1'b1);
      hold(hi);
      set_line(1'b0);
      hold(total - hi);
   endtask

   task automatic push_valid(input int w, input logic [1:0] p);
      exp_t e;
      e.is_err = 1'b0;
      e.width  = 8'(w);
      e.pos    = p;
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.is_err = 1'b1;
      e.width  = 8'd0;
      e.pos    = 2'd0;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pol   = 1'b1;
      set_line(1'b0);
      hold(3);
      checks++; if (o_width !== 8'd0) begin failures++; $display("FAIL rst_width: %0d, required 0", o_width); end
      checks++; if (o_period !== 9'd0) begin failures++; $display("FAIL rst_period: %0d, required 0", o_period); end
      checks++; if (o_position !== 2'd0) begin failures++; $display("FAIL rst_position: %0d, required 0", o_position); end
      checks++; if (o_width_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: %0b, required 0", o_width_valid); end
      checks++; if (o_pulse_err !== 1'b0) begin failures++; $display("FAIL rst_err: %0b, required 0", o_pulse_err); end
      checks++; if (o_signal_lost !== 1'b1) begin failures++; $display("FAIL rst_lost: %0b, required 1", o_signal_lost); end
      rst_n = 1'b1;
      hold(20);
   endtask

   task automatic test_nominal(input string tag);
      for (int i = 0; i < 3; i++) begin
         push_valid(7, POS_1MS);
         frame(7 * P + P / 2, FRAME);
         if (i == 0) begin
            checks++;
            if (o_period !== 9'd0) begin failures++; $display("FAIL %s_period_first: %0d, required 0", tag, o_period); end
            checks++;
            if (o_signal_lost !== 1'b0) begin failures++; $display("FAIL %s_lost_clear: %0b, required 0", tag, o_signal_lost); end
         end
      end
      checks++;
      if (o_period !== 9'd200) begin failures++; $display("FAIL %s_period: %0d, required 200", tag, o_period); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL %s_pending: %0d left, required 0", tag, exp_q.size()); end
   endtask

   task automatic test_positions();
      push_valid(12, POS_1P5MS);
      set_line(1'b1);
      hold(12 * P + P / 2);
      set_line(1'b0);
      hold(LAT - 1);
      checks++;
      if (o_width_valid !== 1'b0) begin failures++; $display("FAIL valid_early: %0b, required 0", o_width_valid); end
      hold(1);
      checks++;
      if (o_width_valid !== 1'b1) begin failures++; $display("FAIL valid_latency: %0b, required 1", o_width_valid); end
      hold(FRAME - (12 * P + P / 2) - LAT);
      push_valid(17, POS_2MS);
      frame(17 * P + P / 2, FRAME);
      checks++;
      if (o_width !== 8'd17 || o_position !== POS_2MS) begin
         failures++; $display("FAIL pos_hold: width=%0d pos=%0d, required 17/2", o_width, o_position);
      end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL pos_pending: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_errors();
      push_err();
      frame(3 * P + P / 2, FRAME);
      push_err();
      frame(30 * P + P / 2, FRAME);
      checks++;
      if (o_width !== 8'd17 || o_position !== POS_2MS) begin
         failures++; $display("FAIL err_hold: width=%0d pos=%0d, required 17/2", o_width, o_position);
      end
      checks++;
      if (o_period !== 9'd200) begin failures++; $display("FAIL err_period: %0d, required 200", o_period); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL err_pending: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_loss();
      push_valid(12, POS_1P5MS);
      set_line(1'b1);
      hold(125);
      set_line(1'b0);
      hold(LAT + 250 * P - 1 - 125);
      checks++;
      if (o_signal_lost !== 1'b0) begin failures++; $display("FAIL lost_early: %0b, required 0", o_signal_lost); end
      hold(1);
      checks++;
      if (o_signal_lost !== 1'b1) begin failures++; $display("FAIL lost_at_250: %0b, required 1", o_signal_lost); end
      hold(50 * P);
      push_valid(15, POS_2MS);
      frame(15 * P + P / 2, FRAME);
      checks++;
      if (o_signal_lost !== 1'b0) begin failures++; $display("FAIL lost_recover: %0b, required 0", o_signal_lost); end
      checks++;
      if (o_width !== 8'd15 || o_position !== POS_2MS) begin
         failures++; $display("FAIL recover_width: width=%0d pos=%0d, required 15/2", o_width, o_position);
      end
      checks++;
      if (o_period !== 9'd200) begin failures++; $display("FAIL recover_period: %0d, required 200", o_period); end
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL loss_pending: %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_polarity();
      rst_n = 1'b0;
      pol   = 1'b0;
      set_line(1'b0);
      hold(3);
      rst_n = 1'b1;
      hold(20);
      test_nominal("inv");
      set_line(1'b1);
      hold(4 * P);
      rst_n = 1'b0;
      hold(1);
      checks++;
      if (o_width !== 8'd0 || o_period !== 9'd0 || o_position !== 2'd0 || o_signal_lost !== 1'b1
          || o_width_valid !== 1'b0 || o_pulse_err !== 1'b0) begin
         failures++;
         $display("FAIL midpulse_reset: width=%0d period=%0d pos=%0d lost=%0b, required 0/0/0/1",
                  o_width, o_period, o_position, o_signal_lost);
      end
      hold(5);
      rst_n = 1'b1;
      hold(12 * P + P / 2 - 4 * P - 6);
      set_line(1'b0);
      hold(FRAME);
      checks++;
      if (o_signal_lost !== 1'b1 || o_width !== 8'd0) begin
         failures++; $display("FAIL partial_pulse: lost=%0b width=%0d, required 1/0", o_signal_lost, o_width);
      end
   endtask

   task automatic test_glitch();
      rst_n = 1'b0;
      pol   = 1'b1;
      set_line(1'b0);
      hold(3);
      rst_n = 1'b1;
      hold(20);
`ifdef GLITCH_FILTER_EN
      push_valid(12, POS_1P5MS);
`else
      push_err();
      push_valid(10, POS_1P5MS);
`endif
      set_line(1'b1);
      hold(20);
      set_line(1'b0);
      hold(2);
      set_line(1'b1);
      hold(103);
      set_line(1'b0);
      hold(FRAME - 125);
      checks++;
`ifdef GLITCH_FILTER_EN
      if (o_width !== 8'd12) begin failures++; $display("FAIL glitch_width: %0d, required 12", o_width); end
`else
      if (o_width !== 8'd10) begin failures++; $display("FAIL glitch_width: %0d, required 10", o_width); end
`endif
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL glitch_pending: %0d left, required 0", exp_q.size()); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_nominal("nom");
      test_positions();
      test_errors();
      test_loss();
      test_polarity();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
